microword_pipe_reg: RTL and testbench
=====================================

// Module: microword_pipe_reg
// PURPOSE
//  Parametrised multi-stage register that carries microinstruction words from the control store to the datapath.
//  Adds reset-to-NOP, flush, stall with bubble collapse and a valid/ready handshake.
//  Sits between the microstore/next-state logic and the datapath control inputs. Carries the 5-bit state tag alongside each word.
// PARAMETERS
//  WORD_W    44          microword width in bits (all control + transition fields packed)
//  STAGES    1           pipeline depth, legal 1..4; end-to-end latency equals STAGES cycles
//  STATE_W   5           width of the state tag travelling with each word
//  NOP_WORD  {WORD_W{1'b0}}  word loaded at reset, at flush and into every bubble (RW=0, all ld=0)
// PORTS
//  clk        in   1        rising-edge clock
//  reset      in   1        synchronous, active-high reset
//  in_word    in   WORD_W   microword from control store
//  in_state   in   STATE_W  state tag for in_word
//  in_valid   in   1        in_word is valid this cycle
//  in_ready   out  1        stage 0 can accept this cycle
//  stall      in   1        datapath cannot consume out_word
//  flush      in   1        discard all in-flight words
//  out_word   out  WORD_W   registered microword to datapath (NOP_WORD whenever out_valid=0)
//  out_state  out  STATE_W  tag of out_word
//  out_valid  out  1        out_word is a real microword
// BEHAVIOUR
//  - Each stage i holds {valid[i], word[i], tag[i]}. The last stage drives the outputs directly, with no output logic.
//  - Reset (sampled at posedge): every valid=0, word=NOP_WORD, tag=0. After reset, out_valid=0, out_word=NOP_WORD, out_state=0, in_ready=1.
//  - Priority per edge: reset > flush > hold/advance.
//  - Flush: every stage becomes a bubble (valid=0, word=NOP_WORD, tag=0), regardless of stall.
//    The in_word presented in the flush cycle is dropped. in_ready is still 1 in that cycle, so no handshake error occurs.
//  - hold[last] = stall & valid[last];  hold[i] = stall & valid[i] & hold[i+1].
//    A stage holds only when it is valid and everything downstream is held, so bubbles collapse during stall.
//  - Non-held stage i>0 loads stage i-1. If stage i-1 is itself non-valid it loads NOP_WORD, tag 0, valid=0.
//  - in_ready = ~hold[0] (combinational from stall and valid bits). Stage 0 loads in_word/in_state/valid=1 when in_valid & in_ready.
//    When not held and in_valid=0, stage 0 loads a bubble.
//  - Latency: a word accepted at edge n appears on out_* after edge n+STAGES-1 (edge n for STAGES=1), when no stalls occur.
//  - Stall with the pipe fully valid freezes all stages; outputs are stable and in_ready=0.
//  - Stall with no valid stages: in_ready=1 and words keep filling toward the output.
//  - Mid-operation reset behaves identically to a flush and also clears the perf counters.
//  - No state is lost or duplicated: every accepted word leaves exactly once, in order, unless flushed.
// CONFIGURATION
//  MICROWORD_PIPE_PERF_EN defined:
//    Adds output issue_cnt [15:0], which increments on every edge with out_valid & ~stall.
//    Adds output stall_cnt [15:0], which increments on every edge with stall & out_valid.
//    Both counters saturate at 16'hFFFF and reset to 0 on reset only (flush does not clear them).
//  MICROWORD_PIPE_PERF_EN undefined: neither port nor counter exists. Core behaviour is identical.
// STRUCTURE
//  - Shared control package:
//    - field-position localparams for the microword (MOV, RW, MARld, MDRld, IRld, PCld, nPCld, RFld, FRld, Cin, mux selects MA..ML, OP5..OP0, N2..N0, Inv, S1, S0, CR4..CR0)
//    - MICROWORD_W, STATE_W
//    - the NOP microword constant
//  - One sub-module, microword_pipe_stage: one {valid, word, tag} register with hold/flush/reset inputs, instantiated STAGES times via generate.
//  - Hold chain and in_ready are computed in the top level.
// TESTING
//  1. Reset: hold reset 2 cycles with in_valid=1, in_word=44'hABC -> out_valid=0, out_word=NOP_WORD, out_state=0, in_ready=1.
//  2. Latency, STAGES=3: inject words 1,2,3 with tags 5'd1..5'd3 on consecutive edges -> word 1 appears after the 3rd edge, then 2 and 3 on following edges, in order.
//  3. Bubble collapse, STAGES=3: pipe {valid,bubble,valid}, stall=1 -> output word holds, bubble is filled by the upstream word next edge, in_ready=1 then 0 once all 3 are valid.
//  4. Flush during stall: full pipe, stall=1, flush=1, in_valid=1 -> next cycle all valid=0, out_word=NOP_WORD, and the presented word never reaches the output.
//  5. Flush + reset simultaneously mid-stream -> identical to reset; with MICROWORD_PIPE_PERF_EN, issue_cnt=stall_cnt=0.
//  6. Perf (macro defined): 10 issues, 4 stall cycles with out_valid=1 -> issue_cnt=10, stall_cnt=4; preload near 16'hFFFF -> saturates, no wrap.

Source files
------------

// File: rtl/microword_pipe_reg_pkg.sv
// rtl/microword_pipe_reg_pkg.sv - microword field map, widths and NOP constant
package microword_pipe_reg_pkg;

  localparam int MICROWORD_W = 44;
  localparam int STATE_W     = 5;

  // Single-bit control fields (bit index within the microword)
  localparam int MW_MOV   = 38;
  localparam int MW_RW    = 37;
  localparam int MW_MARLD = 36;
  localparam int MW_MDRLD = 35;
  localparam int MW_IRLD  = 34;
  localparam int MW_PCLD  = 33;
  localparam int MW_NPCLD = 32;
  localparam int MW_RFLD  = 31;
  localparam int MW_FRLD  = 30;
  localparam int MW_CIN   = 29;

  // Mux selects MA..ML, one bit each, MA highest
  localparam int MW_MA = 28;
  localparam int MW_MB = 27;
  localparam int MW_MC = 26;
  localparam int MW_MD = 25;
  localparam int MW_ME = 24;
  localparam int MW_MF = 23;
  localparam int MW_MG = 22;
  localparam int MW_MH = 21;
  localparam int MW_MI = 20;
  localparam int MW_MJ = 19;
  localparam int MW_MK = 18;
  localparam int MW_ML = 17;

  // Multi-bit fields: LSB position and width
  localparam int MW_OP_LSB  = 11;
  localparam int MW_OP_W    = 6;
  localparam int MW_N_LSB   = 8;
  localparam int MW_N_W     = 3;
  localparam int MW_INV     = 7;
  localparam int MW_S1      = 6;
  localparam int MW_S0      = 5;
  localparam int MW_CR_LSB  = 0;
  localparam int MW_CR_W    = 5;

  // Bits 43..39 are reserved and carried through untouched

  // All loads off and RW=0: the datapath does nothing with this word
  localparam logic [MICROWORD_W-1:0] NOP_MICROWORD = {MICROWORD_W{1'b0}};

endpackage

// File: rtl/microword_pipe_stage.sv
// rtl/microword_pipe_stage.sv - one {valid, word, tag} pipeline register
module microword_pipe_stage #(
  parameter int                WORD_W   = 44,
  parameter int                STATE_W  = 5,
  parameter logic [WORD_W-1:0] NOP_WORD = {WORD_W{1'b0}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               hold_i,
  input  logic               load_valid_i,
  input  logic [WORD_W-1:0]  load_word_i,
  input  logic [STATE_W-1:0] load_tag_i,
  output logic               valid_o,
  output logic [WORD_W-1:0]  word_o,
  output logic [STATE_W-1:0] tag_o
);
  import microword_pipe_reg_pkg::*;

  logic               valid_q, valid_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [STATE_W-1:0] tag_q, tag_d;

  // Flush empties the stage, hold keeps it, otherwise take the upstream slot (bubbles carry NOP)
  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    tag_d   = tag_q;
    if (flush) begin
      valid_d = 1'b0;
      word_d  = NOP_WORD;
      tag_d   = '0;
    end else if (!hold_i) begin
      valid_d = load_valid_i;
      word_d  = load_valid_i ? load_word_i : NOP_WORD;
      tag_d   = load_valid_i ? load_tag_i : '0;
    end
  end

  // State register with synchronous reset to an empty NOP slot
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      word_q  <= NOP_WORD;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
      tag_q   <= tag_d;
    end
  end

  assign valid_o = valid_q;
  assign word_o  = word_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/microword_pipe_reg.sv
// rtl/microword_pipe_reg.sv - STAGES-deep microword pipe with bubble-collapsing stall, flush; MICROWORD_PIPE_PERF_EN adds issue/stall counters
module microword_pipe_reg #(
  parameter int                WORD_W   = microword_pipe_reg_pkg::MICROWORD_W,
  parameter int                STAGES   = 1,
  parameter int                STATE_W  = microword_pipe_reg_pkg::STATE_W,
  parameter logic [WORD_W-1:0] NOP_WORD = {WORD_W{1'b0}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WORD_W-1:0]  in_word,
  input  logic [STATE_W-1:0] in_state,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               stall,
  input  logic               flush,
  output logic [WORD_W-1:0]  out_word,
  output logic [STATE_W-1:0] out_state,
  output logic               out_valid
`ifdef MICROWORD_PIPE_PERF_EN
  ,
  output logic [15:0]        issue_cnt,
  output logic [15:0]        stall_cnt
`endif
);
  import microword_pipe_reg_pkg::*;

  // Stage 0 is the input end, stage STAGES-1 drives the outputs
  logic [STAGES-1:0]  valid_s;
  logic [STAGES-1:0]  hold;
  logic [WORD_W-1:0]  word_s [STAGES];
  logic [STATE_W-1:0] tag_s  [STAGES];

  // A stage holds only while it and every stage downstream of it are valid under stall
  always_comb begin
    logic run;
    hold = '0;
    run  = stall;
    for (int i = STAGES - 1; i >= 0; i--) begin
      run     = run & valid_s[i];
      hold[i] = run;
    end
  end

  // A flushed input word is dropped rather than refused, so ready stays high that cycle
  assign in_ready = flush | ~hold[0];

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic               ld_valid;
    logic [WORD_W-1:0]  ld_word;
    logic [STATE_W-1:0] ld_tag;

    if (g == 0) begin : g_head
      assign ld_valid = in_valid;
      assign ld_word  = in_word;
      assign ld_tag   = in_state;
    end else begin : g_body
      assign ld_valid = valid_s[g-1];
      assign ld_word  = word_s[g-1];
      assign ld_tag   = tag_s[g-1];
    end

    microword_pipe_stage #(
      .WORD_W   (WORD_W),
      .STATE_W  (STATE_W),
      .NOP_WORD (NOP_WORD)
    ) u_stage (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .hold_i       (hold[g]),
      .load_valid_i (ld_valid),
      .load_word_i  (ld_word),
      .load_tag_i   (ld_tag),
      .valid_o      (valid_s[g]),
      .word_o       (word_s[g]),
      .tag_o        (tag_s[g])
    );
  end

  assign out_valid = valid_s[STAGES-1];
  assign out_word  = word_s[STAGES-1];
  assign out_state = tag_s[STAGES-1];

`ifdef MICROWORD_PIPE_PERF_EN
  logic [15:0] issue_cnt_q, issue_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating event counts: words delivered, and cycles a real word sat stalled at the output
  always_comb begin
    issue_cnt_d = issue_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !stall && issue_cnt_q != 16'hFFFF) begin
      issue_cnt_d = issue_cnt_q + 16'd1;
    end
    if (out_valid && stall && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Counters survive flush; only reset clears them
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_cnt_q <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign issue_cnt = issue_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_microword_pipe_reg.sv
// tb/tb_microword_pipe_reg.sv - bench for microword_pipe_reg (STAGES=3 and STAGES=1), MICROWORD_PIPE_PERF_EN aware
module tb_microword_pipe_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        stall = 1'b0;
  logic        in_valid = 1'b0;
  logic [43:0] in_word = '0;
  logic [4:0]  in_state = '0;

  logic        in_ready3, out_valid3, in_ready1, out_valid1;
  logic [43:0] out_word3, out_word1;
  logic [4:0]  out_state3, out_state1;
`ifdef MICROWORD_PIPE_PERF_EN
  logic [15:0] issue_cnt3, stall_cnt3, issue_cnt1, stall_cnt1;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  // Reference: per DUT, slot 0 is the output end; a bubble holds word 0 / tag 0
  bit          mv [2][4];
  logic [43:0] mw [2][4];
  logic [4:0]  mt [2][4];
  logic [15:0] e_issue = '0;
  logic [15:0] e_stall = '0;

  always #5 clk = ~clk;

  microword_pipe_reg #(.WORD_W(44), .STAGES(3), .STATE_W(5), .NOP_WORD(44'h0)) u3 (
    .clk(clk), .reset(reset), .in_word(in_word), .in_state(in_state), .in_valid(in_valid),
    .in_ready(in_ready3), .stall(stall), .flush(flush), .out_word(out_word3),
    .out_state(out_state3), .out_valid(out_valid3)
`ifdef MICROWORD_PIPE_PERF_EN
    , .issue_cnt(issue_cnt3), .stall_cnt(stall_cnt3)
`endif
  );

  microword_pipe_reg #(.WORD_W(44), .STAGES(1), .STATE_W(5), .NOP_WORD(44'h0)) u1 (
    .clk(clk), .reset(reset), .in_word(in_word), .in_state(in_state), .in_valid(in_valid),
    .in_ready(in_ready1), .stall(stall), .flush(flush), .out_word(out_word1),
    .out_state(out_state1), .out_valid(out_valid1)
`ifdef MICROWORD_PIPE_PERF_EN
    , .issue_cnt(issue_cnt1), .stall_cnt(stall_cnt1)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Number of valid words sitting contiguously at the output end
  function automatic int lead_valid(input int d, input int s);
    int k = 0;
    while (k < s && mv[d][k]) k++;
    return k;
  endfunction

  function automatic bit model_ready(input int d, input int s);
    if (flush || !stall) return 1'b1;
    return lead_valid(d, s) < s;
  endfunction

  // Under stall the stalled run at the output stays; everything above the first gap moves one slot closer
  task automatic model_edge(input int d, input int s);
    int k;
    if (reset || flush) begin
      for (int p = 0; p < 4; p++) begin
        mv[d][p] = 1'b0; mw[d][p] = '0; mt[d][p] = '0;
      end
    end else begin
      k = stall ? lead_valid(d, s) : 0;
      if (k < s) begin
        for (int p = k; p < s - 1; p++) begin
          mv[d][p] = mv[d][p+1]; mw[d][p] = mw[d][p+1]; mt[d][p] = mt[d][p+1];
        end
        mv[d][s-1] = in_valid;
        mw[d][s-1] = in_valid ? in_word : 44'h0;
        mt[d][s-1] = in_valid ? in_state : 5'h0;
      end
    end
  endtask

  task automatic step();
    #1;
    if (chk_en) begin
      check("u3_in_ready", {63'h0, in_ready3}, {63'h0, model_ready(0, 3)});
      check("u1_in_ready", {63'h0, in_ready1}, {63'h0, model_ready(1, 1)});
    end
    @(posedge clk);
    if (reset) begin
      e_issue = '0; e_stall = '0;
    end else begin
      if (mv[0][0] && !stall && e_issue != 16'hFFFF) e_issue++;
      if (mv[0][0] && stall && e_stall != 16'hFFFF) e_stall++;
    end
    model_edge(0, 3);
    model_edge(1, 1);
    if (reset) chk_en = 1'b1;
    #1;
    if (chk_en) begin
      check("u3_out_valid", {63'h0, out_valid3}, {63'h0, mv[0][0]});
      check("u3_out_word", {20'h0, out_word3}, {20'h0, mw[0][0]});
      check("u3_out_state", {59'h0, out_state3}, {59'h0, mt[0][0]});
      check("u1_out_valid", {63'h0, out_valid1}, {63'h0, mv[1][0]});
      check("u1_out_word", {20'h0, out_word1}, {20'h0, mw[1][0]});
      check("u1_out_state", {59'h0, out_state1}, {59'h0, mt[1][0]});
`ifdef MICROWORD_PIPE_PERF_EN
      check("u3_issue_cnt", {48'h0, issue_cnt3}, {48'h0, e_issue});
      check("u3_stall_cnt", {48'h0, stall_cnt3}, {48'h0, e_stall});
`endif
    end
  endtask

  task automatic drive(input bit r, input bit f, input bit s, input bit v,
                       input logic [43:0] w, input logic [4:0] t);
    reset = r; flush = f; stall = s; in_valid = v; in_word = w; in_state = t;
  endtask

  typedef struct {
    bit          rst, fl, st, iv;
    logic [43:0] w;
    logic [4:0]  t;
    bit          er;
    bit          ev;
    logic [43:0] ew;
    logic [4:0]  et;
  } vec_t;

  vec_t vecs [17];

  initial begin
    logic [63:0] r;

    // Hand-derived STAGES=3 sequence: latency, bubble collapse, flush under stall, stall on empty pipe
    //             rst fl st iv  word      tag   rdy  ov  oword     ostate
    vecs[0]  = '{0, 0, 0, 1, 44'h1,  5'd1, 1, 0, 44'h0,  5'd0};
    vecs[1]  = '{0, 0, 0, 1, 44'h2,  5'd2, 1, 0, 44'h0,  5'd0};
    vecs[2]  = '{0, 0, 0, 1, 44'h3,  5'd3, 1, 1, 44'h1,  5'd1};
    vecs[3]  = '{0, 0, 0, 0, 44'h0,  5'd0, 1, 1, 44'h2,  5'd2};
    vecs[4]  = '{0, 0, 0, 0, 44'h0,  5'd0, 1, 1, 44'h3,  5'd3};
    vecs[5]  = '{0, 0, 0, 0, 44'h0,  5'd0, 1, 0, 44'h0,  5'd0};
    vecs[6]  = '{0, 0, 0, 1, 44'h10, 5'd4, 1, 0, 44'h0,  5'd0};
    vecs[7]  = '{0, 0, 0, 0, 44'h0,  5'd0, 1, 0, 44'h0,  5'd0};
    vecs[8]  = '{0, 0, 0, 1, 44'h11, 5'd5, 1, 1, 44'h10, 5'd4};
    vecs[9]  = '{0, 0, 1, 1, 44'h12, 5'd6, 1, 1, 44'h10, 5'd4};
    vecs[10] = '{0, 0, 1, 1, 44'h13, 5'd7, 0, 1, 44'h10, 5'd4};
    vecs[11] = '{0, 1, 1, 1, 44'h14, 5'd8, 1, 0, 44'h0,  5'd0};
    vecs[12] = '{0, 0, 1, 1, 44'h15, 5'd9, 1, 0, 44'h0,  5'd0};
    vecs[13] = '{0, 0, 1, 0, 44'h0,  5'd0, 1, 0, 44'h0,  5'd0};
    vecs[14] = '{0, 0, 1, 0, 44'h0,  5'd0, 1, 1, 44'h15, 5'd9};
    vecs[15] = '{0, 0, 1, 0, 44'h0,  5'd0, 1, 1, 44'h15, 5'd9};
    vecs[16] = '{0, 0, 0, 0, 44'h0,  5'd0, 1, 0, 44'h0,  5'd0};

    for (int p = 0; p < 4; p++) begin
      mv[0][p] = 1'b0; mw[0][p] = '0; mt[0][p] = '0;
      mv[1][p] = 1'b0; mw[1][p] = '0; mt[1][p] = '0;
    end

    // Reset held two cycles while a word is offered
    @(posedge clk); #1;
    drive(1, 0, 0, 1, 44'hABC, 5'd3);
    step();
    step();
    drive(0, 0, 0, 0, 44'h0, 5'd0);
    #1;
    check("rst_out_valid", {63'h0, out_valid3}, 64'h0);
    check("rst_out_word", {20'h0, out_word3}, 64'h0);
    check("rst_out_state", {59'h0, out_state3}, 64'h0);
    check("rst_in_ready", {63'h0, in_ready3}, 64'h1);
    check("rst_u1_out_valid", {63'h0, out_valid1}, 64'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].fl, vecs[i].st, vecs[i].iv, vecs[i].w, vecs[i].t);
      #1;
      check($sformatf("vec%0d_in_ready", i), {63'h0, in_ready3}, {63'h0, vecs[i].er});
      step();
      check($sformatf("vec%0d_out_valid", i), {63'h0, out_valid3}, {63'h0, vecs[i].ev});
      check($sformatf("vec%0d_out_word", i), {20'h0, out_word3}, {20'h0, vecs[i].ew});
      check($sformatf("vec%0d_out_state", i), {59'h0, out_state3}, {59'h0, vecs[i].et});
    end

    // Random traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      r = {$urandom, $urandom};
      drive($urandom_range(63) == 0, $urandom_range(15) == 0, $urandom_range(2) == 0,
            $urandom_range(1) == 1, r[43:0], r[48:44]);
      step();
    end

    // Flush and reset together mid-stream
    drive(0, 0, 0, 1, 44'h777, 5'd7); step();
    drive(0, 0, 0, 1, 44'h888, 5'd8); step();
    drive(0, 0, 1, 1, 44'h999, 5'd9); step();
    drive(1, 1, 1, 1, 44'hAAA, 5'd10); step();
    check("rstflush_out_valid", {63'h0, out_valid3}, 64'h0);
    check("rstflush_out_word", {20'h0, out_word3}, 64'h0);
`ifdef MICROWORD_PIPE_PERF_EN
    check("rstflush_issue_cnt", {48'h0, issue_cnt3}, 64'h0);
    check("rstflush_stall_cnt", {48'h0, stall_cnt3}, 64'h0);
`endif

    // Ten issues with four stalled cycles at a valid output
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 44'h100 + 44'(i), 5'(i)); step();
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0, 44'h0, 5'd0); step();
    end
    for (int i = 3; i < 10; i++) begin
      drive(0, 0, 0, 1, 44'h100 + 44'(i), 5'(i)); step();
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 44'h0, 5'd0); step();
    end
    check("drain_out_valid", {63'h0, out_valid3}, 64'h0);
`ifdef MICROWORD_PIPE_PERF_EN
    check("perf_issue_cnt", {48'h0, issue_cnt3}, 64'd10);
    check("perf_stall_cnt", {48'h0, stall_cnt3}, 64'd4);

    // Long stall with a full pipe drives stall_cnt into saturation
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 44'h200 + 44'(i), 5'(i)); step();
    end
    drive(0, 0, 1, 0, 44'h0, 5'd0);
    for (int i = 0; i < 65540; i++) step();
    check("sat_stall_cnt", {48'h0, stall_cnt3}, 64'hFFFF);
    check("sat_issue_cnt", {48'h0, issue_cnt3}, 64'd10);
    check("sat_out_word", {20'h0, out_word3}, 64'h200);
`endif

    drive(0, 0, 0, 0, 44'h0, 5'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
